capture_ctrl: RTL and testbench
===============================

Name: capture_ctrl

Overview:
- Sequences one acquisition from the 64-bit packed ADC word stream (four 16-bit samples per dclk) into a capture memory of 2^ADDR_W words.
- Host arms the block with a word count. The block discards SETTLE cycles so the capture pipeline can flush, then optionally waits for a trigger edge.
- It then writes exactly num_words consecutive words starting at address 0, and flags completion.
- Sits between the capture datapath and the dual-port capture RAM, all in the dclk domain.

Parameters:
ADDR_W, 12, capture memory address width; depth = 2^ADDR_W words
SETTLE, 16, dclk cycles discarded after arm before trigger/capture (minimum 1)

Ports:
dclk  in  1  capture/system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
arm  in  1  start request, sampled each dclk; honoured only in IDLE or DONE
abort  in  1  synchronous abort; returns to IDLE from any state; priority over arm
trig_mode  in  1  0 = capture immediately after settle, 1 = wait for trig rising edge; latched at arm
trig  in  1  external trigger, already synchronous to dclk
num_words  in  ADDR_W+1  words to capture, legal 1..2^ADDR_W; latched at arm
wr_data  in  64  packed sample word from capture datapath
mem_we  out  1  capture RAM write enable
mem_addr  out  ADDR_W  capture RAM write address
mem_din  out  64  capture RAM write data
busy  out  1  high in SETTLE, WAIT_TRIG, CAPTURE
done  out  1  level, high in DONE until next accepted arm or abort
err_len  out  1  one-cycle pulse when arm is rejected for illegal num_words

Behaviour:
- Reset (rst_n low, async): state IDLE; mem_we=0, mem_addr=0, mem_din=0, busy=0, done=0, err_len=0; counters 0; trig_d=0.
- All outputs are registered.
- IDLE/DONE, arm=1, abort=0:
  - If num_words==0 or num_words>2^ADDR_W: err_len pulses for 1 cycle; state is unchanged, and done stays as it was.
  - Otherwise: latch len=num_words and mode=trig_mode, clear done, load settle counter with SETTLE-1, go to SETTLE. busy rises on the same edge.
- SETTLE: decrement the settle counter each cycle. At 0, go to WAIT_TRIG if mode=1, else CAPTURE. This gives exactly SETTLE cycles in SETTLE.
- WAIT_TRIG:
  - trig_d <= trig every cycle in every state.
  - Trigger condition is trig & ~trig_d. A trig held high across entry does not fire; it needs a fresh 0->1 edge.
  - No timeout; leave only via trigger or abort.
- CAPTURE: on each edge while in CAPTURE:
  - mem_we<=1, mem_addr<=wcnt, mem_din<=wr_data, wcnt<=wcnt+1.
  - When wcnt==len-1, go to DONE and clear wcnt.
  - First write is visible the cycle after entering CAPTURE.
  - mem_we is high for exactly len consecutive cycles at addresses 0..len-1 with no gaps.
  - Addresses never wrap because len<=2^ADDR_W. For len=2^ADDR_W the last address is 2^ADDR_W-1.
- DONE:
  - mem_we<=0, busy<=0, done<=1. done rises in the first cycle in which mem_we is low after the last write.
  - mem_addr and mem_din hold their last values.
- arm while busy: ignored, no error, no effect on counters.
- abort in any state (including the same cycle as arm or trigger):
  - Next state IDLE; mem_we<=0, busy<=0, done<=0; wcnt and settle counter cleared.
  - A partially written buffer is left as is.
- err_len is never asserted while busy, and never on a cycle where abort=1.
- Async reset mid-capture: immediate return to reset values, with no further writes.

Test Plan:
1. ADDR_W=4, SETTLE=4, trig_mode=0, num_words=5, one-cycle arm -> busy rises next edge; 4 cycles SETTLE; then mem_we high 5 cycles, addr 0,1,2,3,4, mem_din = wr_data sampled one edge earlier (drive incrementing pattern 0x..00..04); done rises the cycle mem_we falls; busy falls same edge.
2. trig_mode=1, num_words=3, trig held high from before arm -> no capture while held; drop trig, raise it 10 cycles later -> mem_we 3 cycles starting 2 edges after trig rising (edge detect + CAPTURE entry), addr 0..2.
3. num_words=0, then num_words=17 (ADDR_W=4) -> each gives one err_len pulse, state stays IDLE, no mem_we; num_words=16 -> 16 writes, last addr 15, done.
4. Abort at 2nd write of num_words=8 -> mem_we low next edge, busy=0, done=0; re-arm num_words=2 -> writes restart at addr 0.
5. arm pulsed during CAPTURE, and arm+abort in the same cycle while in DONE -> first ignored (write count unchanged); second yields IDLE with done=0 and no new SETTLE.
6. rst_n asserted mid-CAPTURE asynchronously (between edges) -> mem_we, busy, done drop immediately; after release, state IDLE, arm works normally.

Source files
------------

// File: rtl/capture_ctrl.sv
// Sequences one armed acquisition (settle, optional trigger edge, num_words writes) into the capture RAM.
// All outputs registered; first write one cycle after CAPTURE entry; no backpressure, RAM always accepts.
module capture_ctrl #(
   parameter int ADDR_W = 12,
   parameter int SETTLE = 16
) (
   input  logic              dclk,
   input  logic              rst_n,
   input  logic              arm,
   input  logic              abort,
   input  logic              trig_mode,
   input  logic              trig,
   input  logic [ADDR_W:0]   num_words,
   input  logic [63:0]       wr_data,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [63:0]       mem_din,
   output logic              busy,
   output logic              done,
   output logic              err_len
);

   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETTLE,
      S_WAIT,
      S_CAP,
      S_DONE
   } state_t;

   state_t            state, state_nx;
   logic [SW-1:0]     settle_cnt, scnt_nx;
   logic [ADDR_W:0]   wcnt, wcnt_nx;
   logic [ADDR_W:0]   len, len_nx;
   logic              mode, mode_nx;
   logic              trig_d;
   logic              we_nx, busy_nx, done_nx, err_nx;
   logic [ADDR_W-1:0] addr_nx;
   logic [63:0]       din_nx;
   logic              len_ok, fire, last_word;

   assign len_ok    = (num_words != '0) && (num_words <= DEPTH);
   assign fire      = trig & ~trig_d;
   assign last_word = (wcnt == len - ONE);

   always_ff @(posedge dclk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (abort) begin
         state_nx = S_IDLE;
      end else begin
         case (state)
            S_IDLE, S_DONE: if (arm && len_ok) state_nx = S_SETTLE;
            S_SETTLE:       if (settle_cnt == '0) state_nx = mode ? S_WAIT : S_CAP;
            S_WAIT:         if (fire) state_nx = S_CAP;
            S_CAP:          if (last_word) state_nx = S_DONE;
            default:        state_nx = S_IDLE;
         endcase
      end
   end

   always_comb begin
      we_nx   = 1'b0;
      addr_nx = mem_addr;
      din_nx  = mem_din;
      busy_nx = busy;
      done_nx = done;
      err_nx  = 1'b0;
      scnt_nx = settle_cnt;
      wcnt_nx = wcnt;
      len_nx  = len;
      mode_nx = mode;
      if (abort) begin
         busy_nx = 1'b0;
         done_nx = 1'b0;
         scnt_nx = '0;
         wcnt_nx = '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (state == S_DONE) begin
                  busy_nx = 1'b0;
                  done_nx = 1'b1;
               end
               if (arm) begin
                  if (len_ok) begin
                     len_nx  = num_words;
                     mode_nx = trig_mode;
                     done_nx = 1'b0;
                     busy_nx = 1'b1;
                     scnt_nx = SW'(SETTLE - 1);
                  end else begin
                     err_nx = 1'b1;
                  end
               end
            end
            S_SETTLE: if (settle_cnt != '0) scnt_nx = settle_cnt - SW'(1);
            S_CAP: begin
               we_nx   = 1'b1;
               addr_nx = wcnt[ADDR_W-1:0];
               din_nx  = wr_data;
               wcnt_nx = last_word ? '0 : wcnt + ONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge dclk or negedge rst_n) begin
      if (!rst_n) begin
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_din    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err_len    <= 1'b0;
         settle_cnt <= '0;
         wcnt       <= '0;
         len        <= '0;
         mode       <= 1'b0;
         trig_d     <= 1'b0;
      end else begin
         mem_we     <= we_nx;
         mem_addr   <= addr_nx;
         mem_din    <= din_nx;
         busy       <= busy_nx;
         done       <= done_nx;
         err_len    <= err_nx;
         settle_cnt <= scnt_nx;
         wcnt       <= wcnt_nx;
         len        <= len_nx;
         mode       <= mode_nx;
         trig_d     <= trig;
      end
   end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with ADDR_W=4, SETTLE=4.
module tb_capture_ctrl;

   localparam int ADDR_W = 4;
   localparam int SETTLE = 4;

   logic              dclk = 1'b0;
   logic              rst_n = 1'b0;
   logic              arm = 1'b0;
   logic              abort = 1'b0;
   logic              trig_mode = 1'b0;
   logic              trig = 1'b0;
   logic [ADDR_W:0]   num_words = '0;
   logic [63:0]       wr_data = '0;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [63:0]       mem_din;
   logic              busy;
   logic              done;
   logic              err_len;

   int n_tests = 0;
   int n_fail  = 0;

   capture_ctrl #(.ADDR_W(ADDR_W), .SETTLE(SETTLE)) dut (
      .dclk(dclk), .rst_n(rst_n), .arm(arm), .abort(abort),
      .trig_mode(trig_mode), .trig(trig), .num_words(num_words), .wr_data(wr_data),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .busy(busy), .done(done), .err_len(err_len)
   );

   always #5 dclk = ~dclk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge dclk);
      #1;
   endtask

   task automatic arm_go(input int n, input logic mode);
      num_words = n[ADDR_W:0];
      trig_mode = mode;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      check("arm_busy", busy, 1);
      check("arm_done", done, 0);
      check("arm_err", err_len, 0);
   endtask

   // SETTLE edges after the arm edge, still no writes
   task automatic settle();
      for (int i = 0; i < SETTLE; i++) begin
         tick();
         check("settle_we", mem_we, 0);
         check("settle_busy", busy, 1);
      end
   endtask

   task automatic do_capture(input int n, input logic [63:0] base, input int arm_at);
      for (int i = 0; i < n; i++) begin
         wr_data = base + 64'(i);
         if (i == arm_at) begin
            arm = 1'b1;
            num_words = 2;
         end
         tick();
         arm = 1'b0;
         check("cap_we", mem_we, 1);
         check("cap_addr", mem_addr, 64'(i));
         check("cap_din", mem_din, base + 64'(i));
         check("cap_busy", busy, 1);
         check("cap_done", done, 0);
         check("cap_err", err_len, 0);
      end
      wr_data = 64'hdead_beef;
      tick();
      check("end_we", mem_we, 0);
      check("end_done", done, 1);
      check("end_busy", busy, 0);
      check("end_addr", mem_addr, 64'(n - 1));
      check("end_din", mem_din, base + 64'(n - 1));
   endtask

   initial begin
      repeat (3) tick();
      check("rst_we", mem_we, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_din", mem_din, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err_len, 0);
      rst_n = 1'b1;
      tick();

      // 1: immediate capture of 5 words
      arm_go(5, 1'b0);
      settle();
      do_capture(5, 64'h100, -1);

      // 2: trigger held across arm must not fire; fresh edge does
      trig = 1'b1;
      tick();
      arm_go(3, 1'b1);
      settle();
      for (int i = 0; i < 6; i++) begin
         tick();
         check("held_we", mem_we, 0);
         check("held_busy", busy, 1);
      end
      trig = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("low_we", mem_we, 0);
      end
      trig = 1'b1;
      tick();
      check("edge_we", mem_we, 0);
      do_capture(3, 64'h200, -1);
      trig = 1'b0;

      // 3: illegal lengths rejected, full depth accepted
      num_words = 0;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      check("len0_err", err_len, 1);
      check("len0_busy", busy, 0);
      check("len0_done", done, 1);
      tick();
      check("len0_err_clr", err_len, 0);
      check("len0_we", mem_we, 0);
      num_words = 17;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      check("len17_err", err_len, 1);
      check("len17_busy", busy, 0);
      tick();
      check("len17_err_clr", err_len, 0);
      check("len17_we", mem_we, 0);
      check("len17_busy2", busy, 0);
      arm_go(16, 1'b0);
      settle();
      do_capture(16, 64'h300, -1);

      // 4: abort during capture, then re-arm restarts at address 0
      arm_go(8, 1'b0);
      settle();
      wr_data = 64'h350;
      tick();
      check("ab_w0", mem_addr, 0);
      wr_data = 64'h351;
      tick();
      check("ab_w1_we", mem_we, 1);
      check("ab_w1_addr", mem_addr, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("ab_we", mem_we, 0);
      check("ab_busy", busy, 0);
      check("ab_done", done, 0);
      check("ab_addr_hold", mem_addr, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("ab_idle_we", mem_we, 0);
      end
      arm_go(2, 1'b0);
      settle();
      do_capture(2, 64'h400, -1);

      // 5: arm during capture ignored; arm+abort in DONE goes idle
      arm_go(4, 1'b0);
      settle();
      do_capture(4, 64'h500, 1);
      num_words = 3;
      arm = 1'b1;
      abort = 1'b1;
      tick();
      arm = 1'b0;
      abort = 1'b0;
      check("aa_done", done, 0);
      check("aa_busy", busy, 0);
      check("aa_err", err_len, 0);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("aa_idle_busy", busy, 0);
         check("aa_idle_we", mem_we, 0);
      end

      // 6: async reset between edges mid-capture
      arm_go(8, 1'b0);
      settle();
      for (int i = 0; i < 3; i++) begin
         wr_data = 64'h600 + 64'(i);
         tick();
      end
      check("pre_rst_we", mem_we, 1);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_we", mem_we, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      check("arst_addr", mem_addr, 0);
      tick();
      check("arst_hold_we", mem_we, 0);
      rst_n = 1'b1;
      tick();
      check("post_rst_we", mem_we, 0);
      check("post_rst_busy", busy, 0);
      arm_go(1, 1'b0);
      settle();
      do_capture(1, 64'h700, -1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
